// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor on the free-running reference clock: pulses the PLL reset,
// waits for a qualified lock with timeout/retry, and gates the system reset on RUN.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 27000,
  parameter int LOCK_STABLE_CYCLES = 270,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lost_lock_cnt
);

  localparam int MAX_T_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T   = (MAX_T_A > LOCK_STABLE_CYCLES) ? MAX_T_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RTY_W-1:0] retry_cnt, retry_nxt;
  logic [7:0]       lost_nxt;
  logic             lock_meta_p0, lock_s;
  logic             pll_reset_nxt, sys_reset_n_nxt, ready_nxt, fault_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage boundary: two-flop synchroniser, pll_lock -> lock_meta_p0 -> lock_s
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_p0 <= 1'b0;
      lock_s       <= 1'b0;
    end else begin
      lock_meta_p0 <= pll_lock;
      lock_s       <= lock_meta_p0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET_PLL;
      cnt           <= '0;
      retry_cnt     <= '0;
      lost_lock_cnt <= 8'd0;
      pll_reset     <= 1'b1;
      sys_reset_n   <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_cnt     <= retry_nxt;
      lost_lock_cnt <= lost_nxt;
      pll_reset     <= pll_reset_nxt;
      sys_reset_n   <= sys_reset_n_nxt;
      ready         <= ready_nxt;
      fault         <= fault_nxt;
    end
  end

  // relock_req overrides every other transition except while already resetting the PLL
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry_cnt;
    lost_nxt  = lost_lock_cnt;
    if (relock_req && (state != RESET_PLL)) begin
      state_nxt = RESET_PLL;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = STABILIZE;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            cnt_nxt = '0;
            if (retry_cnt == RTY_MAX) begin
              state_nxt = FAULT;
            end else begin
              state_nxt = RESET_PLL;
              retry_nxt = retry_cnt + RTY_W'(1);
            end
          end
        end
        STABILIZE: begin
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STB_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end
        end
        RUN: begin
          cnt_nxt = '0;
          if (!lock_s) begin
            state_nxt = RESET_PLL;
            lost_nxt  = sat_inc8(lost_lock_cnt);
          end
        end
        FAULT: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = RESET_PLL;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register
  always_comb begin
    pll_reset_nxt   = (state_nxt == RESET_PLL) || (state_nxt == FAULT);
    sys_reset_n_nxt = (state_nxt == RUN);
    ready_nxt       = (state_nxt == RUN);
    fault_nxt       = (state_nxt == FAULT);
  end

endmodule
